carry_skip_adder: RTL and testbench

- Registered WIDTH-bit two's-complement/unsigned adder built from a carry-skip (carry-bypass) chain of fixed-size ripple blocks.
- Combinational carry-skip core feeds an output register stage: one result per clock, latency 1 cycle.
- Used as the datapath adder where a low-area adder with better-than-ripple critical path is wanted.

---
 rtl/carry_skip_adder.sv | 55 +++++
 tb/tb_carry_skip_adder.sv | 108 ++++++++++
 2 files changed

// File: rtl/carry_skip_adder.sv
// carry_skip_adder: registered WIDTH-bit carry-skip adder, latency 1 cycle
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset (sum/cout/ovf cleared)
//   in1   : operand A
//   in2   : operand B
//   sum   : registered (in1+in2) mod 2^WIDTH
//   cout  : registered unsigned carry out of the MSB
//   ovf   : registered signed overflow, present only with CSKA_OVERFLOW_FLAG_EN
module carry_skip_adder #(
   parameter int WIDTH = 32,
   parameter int BLOCK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef CSKA_OVERFLOW_FLAG_EN
   ,
   output logic             ovf
`endif
);
   localparam int NB = WIDTH / BLOCK;
   logic [WIDTH-1:0] p;
   logic [WIDTH-1:0] sum_d, sum_q;
   logic [NB:0]      bc;
   logic             cout_d, cout_q;
   assign p     = in1 ^ in2;
   assign bc[0] = 1'b0;
   for (genvar b = 0; b < NB; b++) begin : g_blk
      logic [BLOCK:0] c;
      assign c[0] = bc[b];
      for (genvar i = 0; i < BLOCK; i++) begin : g_bit
         localparam int K = b * BLOCK + i;
         assign sum_d[K] = p[K] ^ c[i];
         assign c[i+1]   = (in1[K] & in2[K]) | (c[i] & p[K]);
      end
      // when every bit propagates, the block carry-in bypasses the ripple chain
      assign bc[b+1] = &p[b*BLOCK +: BLOCK] ? bc[b] : c[BLOCK];
   end
   assign cout_d = bc[NB];
`ifdef CSKA_OVERFLOW_FLAG_EN
   logic ovf_d, ovf_q;
   assign ovf_d = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum_d[WIDTH-1] != in1[WIDTH-1]);
   always_ff @(posedge clk) ovf_q <= !rst_n ? 1'b0 : ovf_d;
   assign ovf = ovf_q;
`endif
   always_ff @(posedge clk) begin
      sum_q  <= !rst_n ? '0 : sum_d;
      cout_q <= !rst_n ? 1'b0 : cout_d;
   end
   assign sum  = sum_q;
   assign cout = cout_q;
endmodule

// File: tb/tb_carry_skip_adder.sv
// tb_carry_skip_adder: directed self-checking bench for carry_skip_adder
//   drives operand pairs with hand-computed sum/cout/ovf and checks reset,
//   one-cycle latency, output stability between edges and carry boundaries
module tb_carry_skip_adder;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] in1, in2, sum;
   logic        cout;
   int          checks = 0;
   int          errors = 0;
`ifdef CSKA_OVERFLOW_FLAG_EN
   logic        ovf;
`endif

   carry_skip_adder #(.WIDTH(32), .BLOCK(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .in1   (in1),
      .in2   (in2),
      .sum   (sum),
      .cout  (cout)
`ifdef CSKA_OVERFLOW_FLAG_EN
      ,
      .ovf   (ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // directed vectors: a, b, expected sum, cout, signed overflow
   logic [31:0] va [9] = '{32'h80000001, 32'h7FFFFFFF, 32'h70FF9FFC, 32'h08F19FFC, 32'hFFFFFFFF,
                           32'h00000000, 32'hFFFF0000, 32'h12345678, 32'h80000000};
   logic [31:0] vb [9] = '{32'h80000001, 32'h7FFFFFFF, 32'hF2FD9FFC, 32'h42FDFF9C, 32'h00000001,
                           32'h00000000, 32'h00010000, 32'h11111111, 32'hFFFFFFFF};
   logic [31:0] vs [9] = '{32'h00000002, 32'hFFFFFFFE, 32'h63FD3FF8, 32'h4BEF9F98, 32'h00000000,
                           32'h00000000, 32'h00000000, 32'h23456789, 32'h7FFFFFFF};
   logic        vc [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
   logic        vv [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   initial begin
      rst_n = 1'b0;
      in1   = 32'h7FFFFFFF;
      in2   = 32'h7FFFFFFF;
      step();
      step();
      check("reset_sum", sum, 32'h0);
      check("reset_cout", {31'b0, cout}, 32'h0);
`ifdef CSKA_OVERFLOW_FLAG_EN
      check("reset_ovf", {31'b0, ovf}, 32'h0);
`endif
      rst_n = 1'b1;
      step();
      check("first_after_reset", sum, 32'hFFFFFFFE);
      for (int k = 0; k < 9; k++) begin
         in1 = va[k];
         in2 = vb[k];
         step();
         check($sformatf("vec%0d_sum", k), sum, vs[k]);
         check($sformatf("vec%0d_cout", k), {31'b0, cout}, {31'b0, vc[k]});
`ifdef CSKA_OVERFLOW_FLAG_EN
         check($sformatf("vec%0d_ovf", k), {31'b0, ovf}, {31'b0, vv[k]});
`endif
      end
      // back-to-back operands, one result per edge
      in1 = 32'h1;
      in2 = 32'h2;
      step();
      check("pipe0_sum", sum, 32'h3);
      in1 = 32'h10;
      in2 = 32'h20;
      #2;
      check("hold_between_edges", sum, 32'h3);
      step();
      check("pipe1_sum", sum, 32'h30);
      // mid-stream reset discards the in-flight result
      in1   = 32'h7FFFFFFF;
      in2   = 32'h7FFFFFFF;
      rst_n = 1'b0;
      step();
      check("midreset_sum", sum, 32'h0);
      check("midreset_cout", {31'b0, cout}, 32'h0);
`ifdef CSKA_OVERFLOW_FLAG_EN
      check("midreset_ovf", {31'b0, ovf}, 32'h0);
`endif
      rst_n = 1'b1;
      step();
      check("postreset_sum", sum, 32'hFFFFFFFE);
      check("postreset_cout", {31'b0, cout}, 32'h0);
`ifdef CSKA_OVERFLOW_FLAG_EN
      check("postreset_ovf", {31'b0, ovf}, 32'h1);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
